// File: rtl/oam_dma_arbiter_pkg.sv
// Shared types and constants for the OAM DMA arbiter and its engine.
// The echo fold maps the E000-FDFF echo region back onto C000-DDFF.
package oam_dma_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2
  } dma_state_e;

  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int          OAM_LEN      = 160;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [7:0]  HI_PAGE      = 8'hFF;
  localparam logic [7:0]  ECHO_FOLD    = 8'h20;
  localparam logic [7:0]  BLOCKED_READ = 8'hFF;

  function automatic logic [7:0] fold_page(input logic [7:0] v);
    return (v >= 8'hE0) ? (v - ECHO_FOLD) : v;
  endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: free-running T-state counter, IDLE/SETUP/XFER sequencer,
// transfer index and the byte carried from the source read to the OAM write.
module oam_dma_engine
  import oam_dma_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       n_reset,
  input  logic       start,
  input  logic [7:0] start_val,
  input  logic [7:0] mem_di,
  output logic [1:0] phase,
  output dma_state_e state,
  output logic [7:0] index,
  output logic [7:0] dma_byte,
  output logic [7:0] dma_reg,
  output logic [7:0] src_page
);

  logic [1:0] phase_q, phase_d;
  dma_state_e state_q, state_d;
  logic [7:0] index_q, index_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] dma_reg_q, dma_reg_d;
  logic [7:0] page_q, page_d;

  always_comb begin
    phase_d   = phase_q + 2'd1;
    state_d   = state_q;
    index_d   = index_q;
    byte_d    = byte_q;
    dma_reg_d = dma_reg_q;
    page_d    = page_q;

    if (start) begin
      dma_reg_d = start_val;
      page_d    = fold_page(start_val);
    end

    if (state_q == XFER && phase_q == 2'd1) byte_d = mem_di;

    // All state changes land on the M-cycle boundary, so a restart always
    // lets the running M-cycle (and its OAM write) finish first.
    if (phase_q == 2'd3) begin
      if (start) begin
        state_d = SETUP;
        index_d = 8'd0;
      end else begin
        case (state_q)
          SETUP: begin
            state_d = XFER;
            index_d = 8'd0;
          end
          XFER: begin
            if (index_q == 8'(OAM_LEN - 1)) begin
              state_d = IDLE;
              index_d = 8'd0;
            end else begin
              index_d = index_q + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      phase_q   <= 2'd0;
      state_q   <= IDLE;
      index_q   <= 8'd0;
      byte_q    <= 8'h00;
      dma_reg_q <= 8'h00;
      page_q    <= 8'h00;
    end else begin
      phase_q   <= phase_d;
      state_q   <= state_d;
      index_q   <= index_d;
      byte_q    <= byte_d;
      dma_reg_q <= dma_reg_d;
      page_q    <= page_d;
    end
  end

  assign phase    = phase_q;
  assign state    = state_q;
  assign index    = index_q;
  assign dma_byte = byte_q;
  assign dma_reg  = dma_reg_q;
  assign src_page = page_q;

endmodule

// File: rtl/oam_dma_arbiter.sv
// Bus arbiter between the CPU and the OAM DMA engine: the FFxx page always
// goes to the high port, the rest of the map is owned by DMA during XFER.
module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
(
  input  logic        CLK,
  input  logic        nRESET,
  input  logic [15:0] CPU_A,
  input  logic [7:0]  CPU_DO,
  input  logic        CPU_RD,
  input  logic        CPU_WR,
  output logic [7:0]  CPU_DI,
  output logic [15:0] MEM_A,
  output logic [7:0]  MEM_DO,
  output logic        MEM_RD,
  output logic        MEM_WR,
  input  logic [7:0]  MEM_DI,
  output logic [7:0]  HI_A,
  output logic [7:0]  HI_DO,
  output logic        HI_RD,
  output logic        HI_WR,
  input  logic [7:0]  HI_DI,
  output logic [1:0]  PHASE,
  output logic        DMA_ACTIVE,
  output logic [7:0]  DMA_REG
);

  logic [1:0] phase;
  dma_state_e state;
  logic [7:0] index;
  logic [7:0] dma_byte;
  logic [7:0] src_page;
  logic       start;
  logic       hi_sel;
  logic       cpu_acc;
  logic       dma_active;

  assign start      = CPU_WR && (CPU_A == DMA_REG_ADDR) && (phase == 2'd3);
  assign hi_sel     = (CPU_A[15:8] == HI_PAGE);
  assign cpu_acc    = CPU_RD || CPU_WR;
  assign dma_active = (state == XFER);

  oam_dma_engine u_engine (
    .clk       (CLK),
    .n_reset   (nRESET),
    .start     (start),
    .start_val (CPU_DO),
    .mem_di    (MEM_DI),
    .phase     (phase),
    .state     (state),
    .index     (index),
    .dma_byte  (dma_byte),
    .dma_reg   (DMA_REG),
    .src_page  (src_page)
  );

  // Writes win over reads when the CPU raises both, keeping RD/WR exclusive.
  always_comb begin
    HI_A   = 8'h00;
    HI_DO  = 8'h00;
    HI_RD  = 1'b0;
    HI_WR  = 1'b0;
    MEM_A  = 16'h0000;
    MEM_DO = 8'h00;
    MEM_RD = 1'b0;
    MEM_WR = 1'b0;

    if (hi_sel && cpu_acc) begin
      HI_A  = CPU_A[7:0];
      HI_WR = CPU_WR;
      HI_RD = CPU_RD && !CPU_WR;
      HI_DO = CPU_WR ? CPU_DO : 8'h00;
    end

    if (dma_active) begin
      if (!phase[1]) begin
        MEM_A  = {src_page, 8'h00} + {8'h00, index};
        MEM_RD = 1'b1;
      end else begin
        MEM_A  = OAM_BASE + {8'h00, index};
        MEM_DO = dma_byte;
        MEM_WR = 1'b1;
      end
    end else if (!hi_sel && cpu_acc) begin
      MEM_A  = CPU_A;
      MEM_WR = CPU_WR;
      MEM_RD = CPU_RD && !CPU_WR;
      MEM_DO = CPU_WR ? CPU_DO : 8'h00;
    end

    if (hi_sel)          CPU_DI = HI_DI;
    else if (dma_active) CPU_DI = BLOCKED_READ;
    else                 CPU_DI = MEM_DI;
  end

  assign PHASE      = phase;
  assign DMA_ACTIVE = dma_active;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench for oam_dma_arbiter: a bus monitor pops an expected
// queue of {source, OAM destination, byte} entries pushed at each DMA start.
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [15:0] cpu_a = 16'h0000;
  logic [7:0]  cpu_do = 8'h00;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_di;
  logic [15:0] mem_a;
  logic [7:0]  mem_do;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_di;
  logic [7:0]  hi_a;
  logic [7:0]  hi_do;
  logic        hi_rd;
  logic        hi_wr;
  logic [7:0]  hi_di = 8'h3C;
  logic [1:0]  phase;
  logic        dma_active;
  logic [7:0]  dma_reg;

  int          chk_cnt = 0;
  int          err_cnt = 0;
  logic [39:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic        cpu_own = 1'b0;
  logic [1:0]  ph_m = 2'd0;

  always #5 clk = ~clk;

  oam_dma_arbiter dut (
    .CLK        (clk),
    .nRESET     (n_reset),
    .CPU_A      (cpu_a),
    .CPU_DO     (cpu_do),
    .CPU_RD     (cpu_rd),
    .CPU_WR     (cpu_wr),
    .CPU_DI     (cpu_di),
    .MEM_A      (mem_a),
    .MEM_DO     (mem_do),
    .MEM_RD     (mem_rd),
    .MEM_WR     (mem_wr),
    .MEM_DI     (mem_di),
    .HI_A       (hi_a),
    .HI_DO      (hi_do),
    .HI_RD      (hi_rd),
    .HI_WR      (hi_wr),
    .HI_DI      (hi_di),
    .PHASE      (phase),
    .DMA_ACTIVE (dma_active),
    .DMA_REG    (dma_reg)
  );

  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    return a[7:0] ^ {a[12:8], a[15:13]} ^ 8'h5A;
  endfunction

  assign mem_di = mem_fn(mem_a);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) ph_m <= n_reset ? ph_m + 2'd1 : 2'd0;

  // Bus monitor: every DMA bus cycle is checked against the queue head.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      check_val("phase", 32'(phase), 32'(ph_m));
      check_val("mem_rd_wr_excl", 32'(mem_rd && mem_wr), 32'd0);
      if (n_reset && (mem_rd || mem_wr) && !cpu_own) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_bus", {mem_rd, mem_wr}, 32'd0);
        end else begin
          if (mem_rd) check_val("dma_src", 32'(mem_a), 32'(exp_q[0][39:24]));
          if (mem_wr) begin
            check_val("dma_dst", 32'(mem_a), 32'(exp_q[0][23:8]));
            check_val("dma_data", 32'(mem_do), 32'(exp_q[0][7:0]));
            if (phase == 2'd3) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_phase3();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (phase != 2'd3 && n < 8);
    if (n >= 8) check_val("phase3_timeout", 32'(n), 32'd0);
  endtask

  task automatic start_dma(input logic [7:0] v, input int exp_left);
    logic [7:0] pg;
    wait_phase3();
    cpu_a  = 16'hFF46;
    cpu_do = v;
    cpu_wr = 1'b1;
    #1;
    check_val("ff46_hi_wr", 32'(hi_wr), 32'd1);
    check_val("ff46_hi_a", 32'(hi_a), 32'h46);
    check_val("ff46_hi_do", 32'(hi_do), 32'(v));
    @(posedge clk);
    #1;
    cpu_wr = 1'b0;
    cpu_a  = 16'h0000;
    cpu_do = 8'h00;
    check_val("dma_reg", 32'(dma_reg), 32'(v));
    if (exp_left >= 0) check_val("restart_left", exp_q.size(), 32'(exp_left));
    exp_q.delete();
    pg = (v >= 8'hE0) ? v - 8'h20 : v;
    for (int i = 0; i < 160; i++) begin
      logic [15:0] src, dst;
      src = {pg, 8'h00} + 16'(i);
      dst = 16'hFE00 + 16'(i);
      exp_q.push_back({src, dst, mem_fn(src)});
    end
  endtask

  // Follows one transfer from the start edge to IDLE; optional CPU pokes.
  task automatic track_xfer(input bit pokes);
    for (int k = 0; k <= 644; k++) begin
      @(negedge clk);
      if (pokes && k >= 100 && k <= 103) begin
        case (k)
          100: begin cpu_a = 16'h8000; cpu_rd = 1'b1; end
          101: begin cpu_a = 16'hC000; cpu_wr = 1'b1; cpu_do = 8'h99; end
          102: begin cpu_a = 16'hFF85; cpu_rd = 1'b1; end
          default: begin cpu_a = 16'hFF0F; cpu_wr = 1'b1; cpu_do = 8'hE1; end
        endcase
      end
      #1;
      if (k == 0 || k == 3) check_val("setup_active", 32'(dma_active), 32'd0);
      if (k == 4 || k == 643) check_val("xfer_active", 32'(dma_active), 32'd1);
      if (k == 644) begin
        check_val("done_active", 32'(dma_active), 32'd0);
        check_val("done_queue", exp_q.size(), 32'd0);
      end
      if (pokes && k == 100) check_val("blk_rd_di", 32'(cpu_di), 32'hFF);
      if (pokes && k == 101) check_val("blk_wr_c000", 32'(mem_wr && mem_a == 16'hC000), 32'd0);
      if (pokes && k == 102) begin
        check_val("hi_rd", 32'(hi_rd), 32'd1);
        check_val("hi_rd_a", 32'(hi_a), 32'h85);
        check_val("hi_rd_di", 32'(cpu_di), 32'(hi_di));
      end
      if (pokes && k == 103) begin
        check_val("hi_wr", 32'(hi_wr), 32'd1);
        check_val("hi_wr_rd", 32'(hi_rd), 32'd0);
        check_val("hi_wr_do", 32'(hi_do), 32'hE1);
      end
      if (pokes && k >= 100 && k <= 103) begin
        @(posedge clk);
        #1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        cpu_a  = 16'h0000;
        cpu_do = 8'h00;
      end
    end
  endtask

  task automatic cpu_mem_read(input logic [15:0] a);
    cpu_own = 1'b1;
    @(negedge clk);
    cpu_a  = a;
    cpu_rd = 1'b1;
    #1;
    check_val("cpu_rd_mem_rd", 32'(mem_rd), 32'd1);
    check_val("cpu_rd_mem_a", 32'(mem_a), 32'(a));
    check_val("cpu_rd_di", 32'(cpu_di), 32'(mem_fn(a)));
    check_val("cpu_rd_hi_rd", 32'(hi_rd), 32'd0);
    @(posedge clk);
    #1;
    cpu_rd  = 1'b0;
    cpu_a   = 16'h0000;
    cpu_own = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_val("rst_phase", 32'(phase), 32'd0);
    check_val("rst_active", 32'(dma_active), 32'd0);
    check_val("rst_dma_reg", 32'(dma_reg), 32'h00);
    check_val("rst_mem_rdwr", {mem_rd, mem_wr}, 32'd0);
    check_val("rst_hi_rdwr", {hi_rd, hi_wr}, 32'd0);
    n_reset = 1'b1;
    mon_en  = 1'b1;

    cpu_mem_read(16'h1234);
    cpu_own = 1'b1;
    @(negedge clk);
    cpu_a  = 16'hC000;
    cpu_do = 8'h77;
    cpu_wr = 1'b1;
    #1;
    check_val("cpu_wr_mem_wr", 32'(mem_wr), 32'd1);
    check_val("cpu_wr_mem_rd", 32'(mem_rd), 32'd0);
    check_val("cpu_wr_mem_a", 32'(mem_a), 32'hC000);
    check_val("cpu_wr_mem_do", 32'(mem_do), 32'h77);
    @(posedge clk);
    #1;
    cpu_wr  = 1'b0;
    cpu_a   = 16'h0000;
    cpu_do  = 8'h00;
    cpu_own = 1'b0;
    #1;
    check_val("idle_mem_a", 32'(mem_a), 32'd0);
    check_val("idle_mem_do", 32'(mem_do), 32'd0);

    start_dma(8'hC1, -1);
    track_xfer(1'b0);

    start_dma(8'hE3, -1);
    track_xfer(1'b1);

    start_dma(8'h80, -1);
    repeat (4 + 50 * 4) @(posedge clk);
    start_dma(8'hD0, 109);
    track_xfer(1'b0);

    start_dma(8'h20, -1);
    repeat (4 + 80 * 4) @(posedge clk);
    @(negedge clk);
    n_reset = 1'b0;
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
    check_val("abort_active", 32'(dma_active), 32'd0);
    check_val("abort_phase", 32'(phase), 32'd0);
    check_val("abort_dma_reg", 32'(dma_reg), 32'h00);
    check_val("abort_mem_wr", 32'(mem_wr), 32'd0);
    cpu_mem_read(16'hC050);
    repeat (20) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/oam_dma_arbiter.md
OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 SHALL have ports CLK in 1 (sole clock, all state on rising edge) and nRESET in 1 (synchronous, active-low).
REQ-002 SHALL have CPU side ports:
- CPU_A in 16
- CPU_DO in 8 (write data)
- CPU_RD in 1
- CPU_WR in 1
- CPU_DI out 8 (read data to core)
REQ-003 SHALL have main bus ports, covering ROM, RAM and OAM 0000-FEFF:
- MEM_A out 16
- MEM_DO out 8
- MEM_RD out 1
- MEM_WR out 1
- MEM_DI in 8
REQ-004 SHALL have high port ports, covering MMIO, HRAM and IE FF00-FFFF:
- HI_A out 8 (low address byte)
- HI_DO out 8
- HI_RD out 1
- HI_WR out 1
- HI_DI in 8
REQ-005 SHALL have status ports:
- PHASE out 2 (current T-state 0..3 of M-cycle)
- DMA_ACTIVE out 1 (CPU main-bus access blocked)
- DMA_REG out 8 (last value written to FF46)

Function
REQ-006 SHALL run a free 2-bit PHASE counter, 0→1→2→3→0, one step per CLK.
REQ-007 SHALL treat a CPU write as a DMA start when CPU_WR=1, CPU_A=FF46 and PHASE=3. The value SHALL be captured into DMA_REG. The write SHALL also pass to the HI port.
REQ-008 SHALL compute source base = {V,8'h00} for V<8'hE0, and {V-8'h20,8'h00} for V>=8'hE0 (echo fold).
REQ-009 SHALL implement states IDLE, SETUP and XFER:
- Start in any state goes to SETUP for exactly one M-cycle, then XFER.
- XFER lasts 160 M-cycles, index 0..159, then returns to IDLE.
REQ-010 In XFER M-cycle i, the bus SHALL be driven as follows:
- PHASE 0-1: MEM_A=base+i, MEM_RD=1.
- MEM_DI SHALL be latched at the PHASE-1 edge.
- PHASE 2-3: MEM_A=16'hFE00+i, MEM_DO=latched byte, MEM_WR=1.
REQ-011 DMA_ACTIVE SHALL be 1 exactly while state=XFER. SETUP SHALL NOT block the CPU.
REQ-012 A CPU access with CPU_A[15:8]=FF SHALL route combinationally to the HI port, regardless of DMA state:
- HI_A=CPU_A[7:0], HI_RD=CPU_RD, HI_WR=CPU_WR, HI_DO=CPU_DO, CPU_DI=HI_DI.
- The MEM port SHALL be untouched.
REQ-013 A CPU access with CPU_A<FF00 while DMA_ACTIVE=0 SHALL route combinationally to the MEM port, with CPU_DI=MEM_DI.
REQ-014 A CPU access with CPU_A<FF00 while DMA_ACTIVE=1 SHALL be blocked:
- Reads SHALL return CPU_DI=8'hFF.
- Writes SHALL be dropped.
- The MEM port SHALL be driven only by DMA.
REQ-015 A restart (FF46 write during SETUP or XFER) SHALL behave as follows:
- The current M-cycle completes, including its OAM write.
- Next M-cycle is SETUP with the new base and index reset to 0.
- DMA_ACTIVE SHALL drop to 0 during that SETUP.
REQ-016 Idle ports SHALL drive RD=WR=0. Idle address/data outputs SHALL be 0.
REQ-017 MEM_RD and MEM_WR SHALL never be 1 simultaneously. HI_RD and HI_WR likewise.

Reset
REQ-018 When nRESET=0 at a CLK edge, the following SHALL hold after that edge:
- PHASE=0, state=IDLE, index=0.
- DMA_REG=8'h00, latched byte=8'h00.
- DMA_ACTIVE=0.
REQ-019 Reset asserted mid-XFER SHALL abort with no further MEM_WR. The CPU SHALL regain the main bus on the next cycle.

Structure
REQ-020 Shared package SHALL hold:
- state enum (IDLE/SETUP/XFER)
- OAM_BASE=16'hFE00
- OAM_LEN=160
- DMA_REG_ADDR=16'hFF46
- HI_PAGE=8'hFF
- ECHO_FOLD=8'h20
- BLOCKED_READ=8'hFF
REQ-021 SHALL contain one sub-module, oam_dma_engine: phase counter, state machine, index and byte latch. Routing/blocking muxes SHALL stay in oam_dma_arbiter.

Verification
REQ-022 Bench SHALL cover these directed scenarios:
- FF46←8'hC1 at PHASE 3 → 4 clocks SETUP (DMA_ACTIVE=0), then 160 M-cycles. First read at C100, write FE00; last read C19F, write FE9F. DMA_ACTIVE=0 after 644 clocks.
- FF46←8'hE3 → source reads C300..C39F (echo fold).
- During XFER, CPU read 0x8000 → CPU_DI=8'hFF with MEM_A driven by DMA. CPU write 0xC000 → no MEM_WR at C000.
- During XFER, CPU read FF85 → HI_RD=1, HI_A=8'h85, CPU_DI=HI_DI. CPU write FF0F → HI_WR=1.
- At index 50, FF46←8'hD0 → index-50 OAM write completes, one SETUP M-cycle (DMA_ACTIVE=0), then reads D000.. and writes FE00...
- nRESET=0 at index 80 → next edge: IDLE, DMA_ACTIVE=0, PHASE=0, no further MEM_WR, DMA_REG=8'h00.
